// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit, initiator side of a word-wide data-memory port.
//
// Accepts one load/store request at a time and drives the data memory, which
// has an asynchronous read and a synchronous write. Byte and halfword stores
// are done as read-modify-write. Load results are sign- or zero-extended.
// Misaligned and out-of-range accesses are reported and never reach memory.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, and req_valid is ignored
// in every other state. resp_valid is a one-cycle pulse. resp_rdata,
// resp_misalign and resp_oor are meaningful only while resp_valid is 1, and
// they read 0 at all other times.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   req_valid/ready  request handshake
//   req_op           0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
//   req_addr         byte address
//   req_wdata        store data (low byte/half used for SB/SH)
//   resp_valid       completion pulse
//   resp_rdata       extended load data (0 for stores and faults)
//   resp_misalign    alignment fault flag
//   resp_oor         out-of-range flag ((addr>>2) >= MEM_DEPTH)
//   mem_address      word-aligned address while accessing memory, else 0
//   mem_writeData    merged word while writing, else 0
//   mem_memWrite     write strobe
//   mem_memRead      read strobe
//   mem_readData     memory read data (may be Z outside READ)
//   dbg_state        current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 RESP)
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_oor,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    output logic        mem_memRead,
    input  logic [31:0] mem_readData,
    output logic [1:0]  dbg_state
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wword;     // store data at accept, merged word after READ
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_oor;

    logic        w_misalign;
    logic        w_oor;
    logic        w_fault;
    logic        w_r_is_load;

    // Fault detection on the incoming request, used at the accept edge.
    always_comb begin
        w_misalign = 1'b0;
        unique case (req_op)
            OP_LW, OP_SW:         w_misalign = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_misalign = req_addr[0];
            default:              w_misalign = 1'b0;
        endcase
    end

    assign w_oor       = ({2'b00, req_addr[31:2]} >= DEPTH_W);
    assign w_fault     = w_misalign | w_oor;
    assign w_r_is_load = (r_op <= OP_LBU);

    // Extend the addressed byte/half of a little-endian word.
    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [2:0]  op,
                                             input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        unique case (op)
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0000, h};
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h000000, b};
            default: load_ext = word;
        endcase
    endfunction

    // Replace the addressed byte/half of the word read back from memory.
    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [2:0]  op,
                                          input logic [1:0]  lane,
                                          input logic [31:0] wdata);
        merge = word;
        if (op == OP_SB) begin
            merge[8*lane +: 8] = wdata[7:0];
        end else if (lane[1]) begin
            merge[31:16] = wdata[15:0];
        end else begin
            merge[15:0] = wdata[15:0];
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_LW;
            r_addr     <= 32'h0;
            r_wword    <= 32'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
            r_oor      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op       <= req_op;
                        r_addr     <= req_addr;
                        r_wword    <= req_wdata;
                        r_rdata    <= 32'h0;
                        r_misalign <= w_misalign;
                        r_oor      <= w_oor;
                        if (w_fault) begin
                            r_state <= S_RESP;
                        end else if (req_op == OP_SW) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_r_is_load) begin
                        r_rdata <= load_ext(mem_readData, r_op, r_addr[1:0]);
                        r_state <= S_RESP;
                    end else begin
                        r_wword <= merge(mem_readData, r_op, r_addr[1:0], r_wword);
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state so reset clears them at once.
    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_rdata    = (r_state == S_RESP) ? r_rdata : 32'h0;
    assign resp_misalign = (r_state == S_RESP) & r_misalign;
    assign resp_oor      = (r_state == S_RESP) & r_oor;
    assign mem_memRead   = (r_state == S_READ);
    assign mem_memWrite  = (r_state == S_WRITE);
    assign mem_address   = (mem_memRead | mem_memWrite) ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_writeData = mem_memWrite ? r_wword : 32'h0;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int DEPTH = 256;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_oor;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_readData;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem     [DEPTH];   // memory attached to the DUT
    logic [31:0] ref_mem [DEPTH];   // reference model's view of memory
    logic [31:0] exp_q [$];         // expected resp_rdata per request

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_oor(resp_oor),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
        .mem_readData(mem_readData), .dbg_state(dbg_state)
    );

    // Data memory: asynchronous read, synchronous write, Z when not read.
    assign mem_readData = mem_memRead ? mem[mem_address[9:2]] : 32'bz;
    always @(posedge clk) begin
        if (mem_memWrite) mem[mem_address[9:2]] <= mem_writeData;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Computes the expected response from the ISA rules and updates ref_mem.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic exp_mis, output logic exp_oor,
                         output int exp_lat, output int exp_nr, output int exp_nw);
        int unsigned idx, size, k;
        logic [31:0] word, part, res, mask;
        idx  = addr / 4;
        k    = addr % 4;
        size = (op == OP_LW || op == OP_SW) ? 4 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        exp_mis = ((addr % size) != 0);
        exp_oor = (idx >= DEPTH);
        res = 32'h0;
        if (exp_mis || exp_oor) begin
            exp_lat = 1; exp_nr = 0; exp_nw = 0;
        end else begin
            word = ref_mem[idx];
            case (op)
                OP_LW: res = word;
                OP_LH, OP_LHU: begin
                    part = (word >> (8 * k)) & 32'hFFFF;
                    res  = (op == OP_LH && part >= 32'h8000) ? (part | 32'hFFFF0000) : part;
                end
                OP_LB, OP_LBU: begin
                    part = (word >> (8 * k)) & 32'hFF;
                    res  = (op == OP_LB && part >= 32'h80) ? (part | 32'hFFFFFF00) : part;
                end
                OP_SW: ref_mem[idx] = wdata;
                OP_SH: begin
                    mask = 32'hFFFF << (8 * k);
                    ref_mem[idx] = (word & ~mask) | ((wdata & 32'hFFFF) << (8 * k));
                end
                default: begin
                    mask = 32'hFF << (8 * k);
                    ref_mem[idx] = (word & ~mask) | ((wdata & 32'hFF) << (8 * k));
                end
            endcase
            exp_nr  = (op == OP_SW) ? 0 : 1;
            exp_nw  = (op >= OP_SW) ? 1 : 0;
            exp_lat = exp_nr + exp_nw + 1;
        end
        exp_q.push_back(res);
    endtask

    // ---------------- driver ----------------
    // req_valid stays high until the response, so the busy states see it held.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        logic e_mis, e_oor;
        int e_lat, e_nr, e_nw;
        int lat, nr, nw, both;
        bit got;
        logic [31:0] e_rd;
        model(op, addr, wdata, e_mis, e_oor, e_lat, e_nr, e_nw);
        @(negedge clk);
        check_eq("idle_ready", {31'b0, req_ready}, 32'd1);
        check_eq("idle_no_resp", {31'b0, resp_valid}, 32'd0);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        got = 0; lat = 0; nr = 0; nw = 0; both = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_memRead && mem_memWrite) both++;
            if (mem_memRead || mem_memWrite)
                check_eq("strobe_addr", mem_address, {addr[31:2], 2'b00});
            if (mem_memRead)  nr++;
            if (mem_memWrite) nw++;
            if (resp_valid) begin
                got = 1;
                lat = c;
            end else begin
                check_eq("busy_ready", {31'b0, req_ready}, 32'd0);
            end
        end
        e_rd = exp_q.pop_front();
        if (!got) begin
            check_eq("resp_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("rdata", resp_rdata, e_rd);
            check_eq("misalign", {31'b0, resp_misalign}, {31'b0, e_mis});
            check_eq("oor", {31'b0, resp_oor}, {31'b0, e_oor});
            check_eq("latency", 32'(lat), 32'(e_lat));
            check_eq("n_read", 32'(nr), 32'(e_nr));
            check_eq("n_write", 32'(nw), 32'(e_nw));
            check_eq("both_strobes", 32'(both), 32'd0);
            check_eq("resp_ready", {31'b0, req_ready}, 32'd0);
            check_eq("resp_addr", mem_address, 32'h0);
        end
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_addr  = $urandom();
        req_wdata = $urandom();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        check_eq({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd0);
        check_eq({tag, "_rdata"}, resp_rdata, 32'h0);
        check_eq({tag, "_flags"}, {30'b0, resp_misalign, resp_oor}, 32'h0);
        check_eq({tag, "_addr"}, mem_address, 32'h0);
        check_eq({tag, "_wdata"}, mem_writeData, 32'h0);
        check_eq({tag, "_strobes"}, {30'b0, mem_memRead, mem_memWrite}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        int          bad;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // SW then LW of the same word
        do_req(OP_SW, 32'h10, 32'hDEADBEEF);
        do_req(OP_LW, 32'h10, 32'h0);

        // byte store and byte loads
        do_req(OP_SW, 32'h20, 32'h11223344);
        do_req(OP_SB, 32'h22, 32'h000000AA);
        check_eq("sb_word", mem[8], 32'h11AA3344);
        do_req(OP_LB,  32'h22, 32'h0);
        do_req(OP_LBU, 32'h22, 32'h0);

        // half store and half loads
        do_req(OP_SW, 32'h20, 32'h11223344);
        do_req(OP_SH, 32'h22, 32'h00008001);
        check_eq("sh_word", mem[8], 32'h80013344);
        do_req(OP_LH,  32'h22, 32'h0);
        do_req(OP_LHU, 32'h22, 32'h0);

        // faults
        do_req(OP_LW, 32'h13, 32'h0);
        do_req(OP_SH, 32'h21, 32'h1234);
        do_req(OP_LW, 32'h400, 32'h0);
        do_req(OP_LW, 32'h3FC, 32'h0);
        do_req(OP_SB, 32'h401, 32'h55);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) addr = 32'h400 + $urandom_range(0, 4096);
            else                           addr = $urandom_range(0, DEPTH * 4 - 1);
            do_req(op, addr, $urandom());
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_eq("mem_image", 32'(bad), 32'd0);

        // asynchronous reset in the middle of a SW: the write must not happen
        mem[4] = 32'h01020304;
        ref_mem[4] = 32'h01020304;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        check_eq("pre_reset_write", {31'b0, mem_memWrite}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_word_kept", mem[4], 32'h01020304);
        @(negedge clk);
        rst_n = 1'b1;
        do_req(OP_LW, 32'h10, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
